// File: rtl/board_ctrl.sv
// board_ctrl: paddle controller feeding the VGA display stage.
// Synchronizes and debounces the left/right buttons, derives a per-frame tick
// from vsync, and moves the board once per frame with a speed ramp while a
// button is held, clamping the board inside the visible width.
module board_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int SCREEN_W        = 640,
  parameter int BOARD_W         = 64,
  parameter int BOARD_Y         = 464,
  parameter int X_INIT          = 288,
  parameter int SPEED_MIN       = 2,
  parameter int SPEED_MAX       = 8,
  parameter int RAMP_FRAMES     = 8
) (
  input  logic       dclk,
  input  logic       rst,
  input  logic       btn_l,
  input  logic       btn_r,
  input  logic       vsync,
  output logic [9:0] board_x,
  output logic [9:0] board_y,
  output logic       frame_tick
);

  localparam int DBW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HCW = (RAMP_FRAMES > 2) ? $clog2(RAMP_FRAMES) : 1;
  localparam logic [10:0] X_MAX = 11'(SCREEN_W - BOARD_W);

  typedef enum logic [1:0] {IDLE, MOVE_L, MOVE_R} state_t;

  logic           btn_l_s1, btn_l_s2, btn_r_s1, btn_r_s2;
  logic           vsync_s1, vsync_s2, vsync_d;
  logic           btn_l_db, btn_r_db;
  logic [DBW-1:0] btn_l_cnt, btn_r_cnt;
  state_t         state, state_next;
  logic [3:0]     speed;
  logic [HCW-1:0] hold_cnt;
  logic           move_l, move_r;
  logic [9:0]     x_left;
  logic [10:0]    x_sum;
  logic [9:0]     x_right;

  // Two-flop synchronizers; vsync flops reset high so reset never fakes a falling edge.
  always_ff @(posedge dclk or posedge rst) begin
    if (rst) begin
      btn_l_s1 <= 1'b0;
      btn_l_s2 <= 1'b0;
      btn_r_s1 <= 1'b0;
      btn_r_s2 <= 1'b0;
      vsync_s1 <= 1'b1;
      vsync_s2 <= 1'b1;
    end else begin
      btn_l_s1 <= btn_l;
      btn_l_s2 <= btn_l_s1;
      btn_r_s1 <= btn_r;
      btn_r_s2 <= btn_r_s1;
      vsync_s1 <= vsync;
      vsync_s2 <= vsync_s1;
    end
  end

  // Left debounce: accept a change only after it has been stable long enough.
  always_ff @(posedge dclk or posedge rst) begin
    if (rst) begin
      btn_l_db  <= 1'b0;
      btn_l_cnt <= '0;
    end else if (btn_l_s2 == btn_l_db) begin
      btn_l_cnt <= '0;
    end else if (btn_l_cnt == DBW'(DEBOUNCE_CYCLES - 1)) begin
      btn_l_db  <= btn_l_s2;
      btn_l_cnt <= '0;
    end else begin
      btn_l_cnt <= btn_l_cnt + 1'b1;
    end
  end

  // Right debounce: same scheme as the left button.
  always_ff @(posedge dclk or posedge rst) begin
    if (rst) begin
      btn_r_db  <= 1'b0;
      btn_r_cnt <= '0;
    end else if (btn_r_s2 == btn_r_db) begin
      btn_r_cnt <= '0;
    end else if (btn_r_cnt == DBW'(DEBOUNCE_CYCLES - 1)) begin
      btn_r_db  <= btn_r_s2;
      btn_r_cnt <= '0;
    end else begin
      btn_r_cnt <= btn_r_cnt + 1'b1;
    end
  end

  // Registered one-cycle pulse on each falling edge of synced vsync.
  always_ff @(posedge dclk or posedge rst) begin
    if (rst) begin
      vsync_d    <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      vsync_d    <= vsync_s2;
      frame_tick <= vsync_d & ~vsync_s2;
    end
  end

  // State register.
  always_ff @(posedge dclk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state straight from the debounced buttons; both pressed means stop.
  always_comb begin
    state_next = IDLE;
    case ({btn_l_db, btn_r_db})
      2'b10:   state_next = MOVE_L;
      2'b01:   state_next = MOVE_R;
      default: state_next = IDLE;
    endcase
  end

  // Decode the registered state into movement enables.
  always_comb begin
    move_l = 1'b0;
    move_r = 1'b0;
    case (state)
      MOVE_L:  move_l = 1'b1;
      MOVE_R:  move_r = 1'b1;
      default: begin
        move_l = 1'b0;
        move_r = 1'b0;
      end
    endcase
  end

  // Speed ramp: restart on idle or direction change, step up every RAMP_FRAMES moving ticks.
  always_ff @(posedge dclk or posedge rst) begin
    if (rst) begin
      speed    <= 4'(SPEED_MIN);
      hold_cnt <= '0;
    end else if (state == IDLE || state_next != state) begin
      speed    <= 4'(SPEED_MIN);
      hold_cnt <= '0;
    end else if (frame_tick) begin
      if (hold_cnt == HCW'(RAMP_FRAMES - 1)) begin
        hold_cnt <= '0;
        if (speed < 4'(SPEED_MAX)) speed <= speed + 1'b1;
      end else begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

  // Candidate positions: left saturates at 0, right sum is 11 bits and clamps to the edge.
  always_comb begin
    x_left  = (board_x >= {6'd0, speed}) ? (board_x - {6'd0, speed}) : 10'd0;
    x_sum   = {1'b0, board_x} + {7'd0, speed};
    x_right = (x_sum > X_MAX) ? X_MAX[9:0] : x_sum[9:0];
  end

  // Board position moves at most once per frame, using the old speed.
  always_ff @(posedge dclk or posedge rst) begin
    if (rst) begin
      board_x <= 10'(X_INIT);
    end else if (frame_tick) begin
      if (move_l)      board_x <= x_left;
      else if (move_r) board_x <= x_right;
    end
  end

  assign board_y = 10'(BOARD_Y);

endmodule

// File: tb/tb_board_ctrl.sv
// tb_board_ctrl: directed self-checking bench for board_ctrl with a short debounce.
module tb_board_ctrl;

  logic       dclk = 1'b0;
  logic       rst;
  logic       btn_l, btn_r, vsync;
  logic [9:0] board_x, board_y, board_x5, board_y5;
  logic       frame_tick, frame_tick5;

  int vectors = 0;
  int miscompares = 0;

  always #20 dclk = ~dclk;

  board_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .dclk(dclk), .rst(rst), .btn_l(btn_l), .btn_r(btn_r), .vsync(vsync),
    .board_x(board_x), .board_y(board_y), .frame_tick(frame_tick)
  );

  board_ctrl #(.DEBOUNCE_CYCLES(4), .X_INIT(5)) dut5 (
    .dclk(dclk), .rst(rst), .btn_l(btn_l), .btn_r(btn_r), .vsync(vsync),
    .board_x(board_x5), .board_y(board_y5), .frame_tick(frame_tick5)
  );

  // Single comparison point: counts every vector and reports any miscompare.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // One frame: vsync low for 2 cycles, then high; board_x has settled when this returns.
  task automatic applyStimulus(input int frames);
    for (int f = 0; f < frames; f++) begin
      @(negedge dclk) vsync = 1'b0;
      repeat (2) @(negedge dclk);
      vsync = 1'b1;
      repeat (10) @(negedge dclk);
    end
  endtask

  task automatic doReset();
    @(negedge dclk) rst = 1'b1;
    repeat (2) @(negedge dclk);
    rst = 1'b0;
    repeat (2) @(negedge dclk);
  endtask

  int x_m, spd_m, hold_m, ticks;

  initial begin
    rst = 1'b1; btn_l = 1'b0; btn_r = 1'b0; vsync = 1'b1;
    #1;
    checkOutput("reset_x", board_x, 288);
    checkOutput("reset_y", board_y, 464);
    checkOutput("reset_tick", frame_tick, 0);
    checkOutput("reset_x5", board_x5, 5);
    repeat (3) @(negedge dclk);
    rst = 1'b0;
    repeat (2) @(negedge dclk);

    // Short right glitch must be ignored.
    $display("[TB] glitch rejection");
    btn_r = 1'b1;
    repeat (3) @(negedge dclk);
    btn_r = 1'b0;
    for (int f = 0; f < 5; f++) begin
      applyStimulus(1);
      checkOutput("glitch_x", board_x, 288);
      checkOutput("glitch_db", dut.btn_r_db, 0);
    end

    // Hold right from reset: ramp then clamp at 576.
    $display("[TB] right hold ramp");
    doReset();
    btn_r = 1'b1;
    repeat (10) @(negedge dclk);
    x_m = 288; spd_m = 2; hold_m = 0;
    for (int t = 1; t <= 62; t++) begin
      applyStimulus(1);
      x_m = (x_m + spd_m > 576) ? 576 : x_m + spd_m;
      if (hold_m == 7) begin
        hold_m = 0;
        spd_m = (spd_m < 8) ? spd_m + 1 : 8;
      end else begin
        hold_m++;
      end
      checkOutput($sformatf("ramp_x_t%0d", t), board_x, x_m);
      checkOutput($sformatf("ramp_speed_t%0d", t), dut.speed, spd_m);
      if (t == 8) checkOutput("tick8_x", board_x, 304);
      if (t == 9) checkOutput("tick9_x", board_x, 307);
    end
    checkOutput("clamp_x", board_x, 576);

    // Both pressed holds, then left alone moves at minimum speed.
    $display("[TB] both buttons then left");
    btn_l = 1'b1;
    repeat (10) @(negedge dclk);
    applyStimulus(2);
    checkOutput("both_x", board_x, 576);
    btn_r = 1'b0;
    repeat (10) @(negedge dclk);
    applyStimulus(1);
    checkOutput("left_after_both_x", board_x, 574);

    // Asynchronous reset mid-cycle takes effect without a clock edge.
    $display("[TB] async reset");
    btn_l = 1'b0;
    repeat (10) @(negedge dclk);
    #5 rst = 1'b1;
    #1;
    checkOutput("async_x", board_x, 288);
    checkOutput("async_y", board_y, 464);
    checkOutput("async_tick", frame_tick, 0);
    repeat (2) @(negedge dclk);
    rst = 1'b0;
    ticks = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge dclk);
      if (frame_tick) ticks++;
    end
    checkOutput("no_tick_after_reset", ticks, 0);
    checkOutput("post_reset_x", board_x, 288);

    // Left hold from X_INIT=5 saturates at 0.
    $display("[TB] left underflow clamp");
    doReset();
    checkOutput("x5_start", board_x5, 5);
    btn_l = 1'b1;
    repeat (10) @(negedge dclk);
    applyStimulus(1); checkOutput("x5_f1", board_x5, 3);
    applyStimulus(1); checkOutput("x5_f2", board_x5, 1);
    applyStimulus(1); checkOutput("x5_f3", board_x5, 0);
    applyStimulus(1); checkOutput("x5_f4", board_x5, 0);
    applyStimulus(1); checkOutput("x5_f5", board_x5, 0);
    btn_l = 1'b0;

    // Tick timing: one pulse per vsync fall, third edge after the fall, one cycle wide.
    $display("[TB] frame tick timing");
    doReset();
    for (int p = 0; p < 3; p++) begin
      ticks = 0;
      for (int c = 0; c < 100; c++) begin
        @(negedge dclk);
        if (frame_tick) ticks++;
        if (c == 2) checkOutput($sformatf("tick_early_p%0d", p), frame_tick, 0);
        if (c == 3) checkOutput($sformatf("tick_at3_p%0d", p), frame_tick, 1);
        if (c == 4) checkOutput($sformatf("tick_width_p%0d", p), frame_tick, 0);
        if (c == 0) vsync = 1'b0;
        if (c == 2) vsync = 1'b1;
      end
      checkOutput($sformatf("ticks_per_pulse_p%0d", p), ticks, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/board_ctrl.md
# board_ctrl

Paddle controller that sits directly upstream of the VGA display stage. It turns the left/right push-buttons into the board position (`board_x`, `board_y`) that the display draws. Buttons are synchronized and debounced. Movement is applied once per frame, timed off the display's `vsync`, with speed ramping while a button is held and the board clamped to the visible 640-pixel width. Everything runs in the 25 MHz pixel clock domain.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 250000: consecutive stable cycles needed to accept a button change (10 ms at 25 MHz).
- `SCREEN_W`, default 640: active width in pixels.
- `BOARD_W`, default 64: board width in pixels.
- `BOARD_Y`, default 464: fixed vertical board position.
- `X_INIT`, default 288: board_x after reset (centered).
- `SPEED_MIN`, default 2: pixels per frame at movement start.
- `SPEED_MAX`, default 8: speed ceiling.
- `RAMP_FRAMES`, default 8: moving frames per +1 speed step.

Ports:
- `dclk` input 1: pixel clock, 25 MHz; all logic on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `btn_l` input 1: raw left button, asynchronous, active high.
- `btn_r` input 1: raw right button, asynchronous, active high.
- `vsync` input 1: active-low vertical sync from the display stage.
- `board_x` output 10: board left edge, 0..SCREEN_W-BOARD_W.
- `board_y` output 10: board top edge.
- `frame_tick` output 1: one-cycle pulse per frame.

## Operation
- **Synchronizers:** two-flop synchronizer on each of `btn_l`, `btn_r`, `vsync`.
- **Debounce (one per button):**
  - A counter increments while the synced input differs from the debounced value; it clears when they agree.
  - When the count reaches DEBOUNCE_CYCLES-1 while still differing, the debounced value takes the synced value and the counter clears.
- **Frame tick:** `frame_tick`=1 for exactly one cycle on each 1→0 transition of synced `vsync`, detected against a registered copy of synced `vsync`.
- **State machine:** states IDLE, MOVE_L, MOVE_R. Next state is evaluated every cycle from the debounced buttons:
  - left only → MOVE_L
  - right only → MOVE_R
  - neither, or both → IDLE
  - Direct MOVE_L↔MOVE_R transitions are allowed.
- **Speed/ramp registers:** `speed` (4 bits) and `hold_cnt`.
  - Both are set to SPEED_MIN / 0 in IDLE and on any state change.
  - A state change overrides a ramp step in the same cycle.
- **Movement:** on a cycle with `frame_tick`=1, using the registered state and speed:
  - MOVE_L: `board_x` ← (`board_x` ≥ `speed`) ? `board_x`−`speed` : 0.
  - MOVE_R: `board_x` ← min(`board_x`+`speed`, SCREEN_W−BOARD_W). The sum is computed at 11 bits, so there is no wrap.
  - IDLE: `board_x` holds.
- **Ramp:** on a moving tick, `hold_cnt` increments. If `hold_cnt`==RAMP_FRAMES−1 on that tick, `hold_cnt` ← 0 and `speed` ← min(`speed`+1, SPEED_MAX). The move on that tick uses the old speed.
- **Vertical position:** `board_y` is constant BOARD_Y.

## Timing
- **Reset values (immediate, asynchronous):**
  - Outputs: `board_x`=X_INIT, `board_y`=BOARD_Y, `frame_tick`=0.
  - Internal: state IDLE, `speed`=SPEED_MIN, `hold_cnt`=0, debounced buttons 0, debounce counters 0.
  - Synchronizers: button flops 0; `vsync` flops and edge register 1, so no false tick is generated after reset.
- **Button latency:** raw edge → debounced change = 2 + DEBOUNCE_CYCLES cycles. The state register changes 1 cycle later.
- **Frame tick latency:** raw `vsync` falling edge → `frame_tick` high after 3 rising edges.
- **Position latency:** `board_x` is updated on the edge following the `frame_tick` cycle, i.e. it is registered and the new value is visible 1 cycle after the tick. One update per frame, maximum.
- **Glitches:** a button glitch shorter than DEBOUNCE_CYCLES has no effect.
- **Reset mid-frame or mid-move:** all state is restored immediately; the first tick after reset release needs a fresh `vsync` falling edge.

## Test plan
Bench uses DEBOUNCE_CYCLES=4 and all other parameters at default.
1. Assert `rst` mid-run with `board_x`≠288 → `board_x`=288, `board_y`=464, `frame_tick`=0 immediately, without waiting for a clock edge; no tick until the next `vsync` fall.
2. `btn_r` high for 3 cycles then low; run 5 frames → `board_x` stays 288; state never leaves IDLE.
3. Hold `btn_r` from reset → ticks 1–8 move +2 each (`board_x`=304 after tick 8), tick 9 gives 307; speed saturates at 8 and never exceeds it.
4. Keep holding `btn_r` → `board_x` reaches exactly 576 and stays 576 on further ticks. Then press `btn_l` as well (both pressed) → IDLE, `board_x` holds. Release `btn_r` → MOVE_L at speed 2: 576→574.
5. With X_INIT=5, hold `btn_l` → `board_x` goes 5→3→1→0, then stays 0 with no underflow wrap.
6. Pulse `vsync` low for 2 cycles every 100 cycles → exactly one `frame_tick` per pulse, 3 cycles after each falling edge, one cycle wide.
